// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, parameter defaults and 8N1 line levels.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rdi_if.sv
// Received-byte handshake: one-entry holding register with valid/ready flow control.
interface uart_rdi_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_rd;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output data_rd, rx_valid, input rx_ready);
  modport slave  (input data_rd, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rdi.sv
// UART 8N1 receiver: oversampled start/data/stop recovery feeding a valid/ready holding register.
module uart_rdi
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_tick,
  input  logic       rdi,
  uart_rdi_if.master rx,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 rdi_s;
  logic                 frame_done;
  logic                 stop_bad;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rdi),
    .q       (rdi_s)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    if (sample_tick) begin
      tick_d = tick_q + TW'(1);
      case (state_q)
        IDLE: begin
          tick_d = '0;
          bit_d  = '0;
          if (rdi_s == START_BIT) state_d = START;
        end
        START: begin
          // Mid start bit: a line already back high was only a glitch.
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = (rdi_s == START_BIT) ? DATA : IDLE;
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rdi_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rdi_s == STOP_BIT) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = BREAK;
            end
          end
        end
        BREAK: begin
          tick_d = '0;
          if (rdi_s == IDLE_LEVEL) state_d = IDLE;
        end
        default: begin
          tick_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // A completing frame overwrites the held byte only if that byte is being accepted in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (frame_done) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.data_rd  = data_q;
  assign rx.rx_valid = valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rdi.sv
// Self-checking bench for uart_rdi: vector table, hand-written corner sequences and random frames.
module tb_uart_rdi;

  localparam int OS        = 16;
  localparam int TICK_DIV  = 4;
  localparam int BIT_CLKS  = OS * TICK_DIV;
  localparam int STOP_TICK = OS / 2 + 9 * OS;

  logic clk = 1'b0;
  logic reset_n;
  logic sample_tick = 1'b0;
  logic rdi;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rdi_if #(.DATA_BITS(8)) bus ();

  uart_rdi #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .rdi         (rdi),
    .rx          (bus),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int tick_div = 0;
  always @(negedge clk) begin
    tick_div    = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
    sample_tick = (tick_div == 0);
  end

  int tests = 0;
  int fails = 0;

  // Monitor: observes just before each rising edge what the DUT is about to act on.
  logic [7:0] got_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         viol     = 0;
  logic       ferr_prev = 1'b0, ovr_prev = 1'b0, valid_prev = 1'b0, acc_prev = 1'b0;
  logic [7:0] data_prev = '0;

  always @(negedge clk) begin
    #3;
    if (reset_n) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) viol++;
      if ((frame_err && ferr_prev) || (overrun && ovr_prev)) viol++;
      if (valid_prev && !acc_prev && bus.rx_valid && bus.data_rd !== data_prev) viol++;
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.data_rd);
      ferr_prev  = frame_err;
      ovr_prev   = overrun;
      valid_prev = bus.rx_valid;
      acc_prev   = bus.rx_valid & bus.rx_ready;
      data_prev  = bus.data_rd;
    end else begin
      ferr_prev  = 1'b0;
      ovr_prev   = 1'b0;
      valid_prev = 1'b0;
      acc_prev   = 1'b0;
    end
  end

  // Reference model: what the consumer should see, frame by frame.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr  = 0;
  bit         model_full = 1'b0;

  function automatic void model_frame(input logic [7:0] d, input bit ok, input bit ready_now);
    if (!ok) exp_ferr++;
    else if (model_full && !ready_now) exp_ovr++;
    else begin
      exp_q.push_back(d);
      model_full = !ready_now;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_q(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic b, input int nbits);
    rdi = b;
    repeat (nbits * BIT_CLKS) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    drive_bits(1'b0, 1);
    for (int unsigned i = 0; i < 8; i++) drive_bits(d[i], 1);
    drive_bits(stop_ok ? 1'b1 : 1'b0, 1);
  endtask

  // Called together with send_frame; returns on the rising edge of sample tick number target,
  // counting from the first tick on which the synchronized start bit is visible (index 0).
  task automatic wait_ticks_from_start(input int target);
    int n;
    n = -1;
    repeat (3) @(posedge clk);
    while (1) begin
      if (sample_tick) n++;
      if (n == target) break;
      @(posedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_count;
    logic [7:0] exp_byte;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int f0, o0;
    logic [7:0] d;
    bit ok;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 8'h01, 0};

    reset_n      = 1'b0;
    rdi          = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) step();
    check("rst_data", 32'(bus.data_rd), 32'h0);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    drive_bits(1'b1, 1);

    // Latency: rx_valid rises on the stop-bit sample edge and drops one clock later.
    got_q.delete();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_ticks_from_start(STOP_TICK - 1);
        #2;
        check("lat_before", 32'(bus.rx_valid), 32'h0);
        repeat (TICK_DIV) @(posedge clk);
        #2;
        check("lat_valid", 32'(bus.rx_valid), 32'h1);
        check("lat_data", 32'(bus.data_rd), 32'hA5);
        @(posedge clk);
        #2;
        check("lat_drop", 32'(bus.rx_valid), 32'h0);
      end
    join
    drive_bits(1'b1, 1);
    check("lat_got", 32'(got_q.size()), 32'h1);

    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok);
      if (!vecs[i].stop_ok) drive_bits(1'b0, 1);
      drive_bits(1'b1, 2);
      check($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'(vecs[i].exp_count));
      if (got_q.size() > 0) check($sformatf("vec%0d_byte", i), 32'(got_q[0]), 32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'h0);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      exp_ferr += vecs[i].exp_ferr;
    end

    // Start glitch shorter than half a bit.
    got_q.delete();
    f0  = ferr_cnt;
    rdi = 1'b0;
    repeat (10) step();
    check("glitch_busy", 32'(busy), 32'h1);
    repeat (2) step();
    drive_bits(1'b1, 2);
    check("glitch_idle", 32'(busy), 32'h0);
    check("glitch_nobyte", 32'(got_q.size()), 32'h0);
    check("glitch_noferr", 32'(ferr_cnt - f0), 32'h0);

    // Back-to-back frames with no idle gap.
    got_q.delete();
    exp_q.delete();
    send_frame(8'h00, 1'b1); model_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1); model_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1); model_frame(8'h55, 1'b1, 1'b1);
    drive_bits(1'b1, 2);
    compare_q("b2b");

    // Overrun while the consumer stalls, then accept coinciding with a completion.
    got_q.delete();
    exp_q.delete();
    bus.rx_ready = 1'b0;
    model_full   = 1'b0;
    send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1, 1'b0);
    drive_bits(1'b1, 1);
    check("ovr_held_valid", 32'(bus.rx_valid), 32'h1);
    check("ovr_held_data", 32'(bus.data_rd), 32'h11);
    send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1, 1'b0);
    drive_bits(1'b1, 1);
    check("ovr_pulse", 32'(ovr_cnt), 32'(exp_ovr));
    check("ovr_kept_data", 32'(bus.data_rd), 32'h11);
    fork
      send_frame(8'h33, 1'b1);
      begin
        wait_ticks_from_start(STOP_TICK - 1);
        repeat (TICK_DIV - 1) @(posedge clk);
        @(negedge clk);
        #1 bus.rx_ready = 1'b1;
        @(negedge clk);
        #1 bus.rx_ready = 1'b0;
      end
    join
    model_frame(8'h33, 1'b1, 1'b1);
    drive_bits(1'b1, 1);
    check("same_cycle_data", 32'(bus.data_rd), 32'h33);
    check("same_cycle_valid", 32'(bus.rx_valid), 32'h1);
    check("same_cycle_ovr", 32'(ovr_cnt), 32'(exp_ovr));
    bus.rx_ready = 1'b1;
    model_full   = 1'b0;
    drive_bits(1'b1, 1);
    compare_q("ovr");

    // Asynchronous reset in the middle of a data bit.
    got_q.delete();
    exp_q.delete();
    drive_bits(1'b0, 1);
    drive_bits(1'b1, 3);
    repeat (20) step();
    check("mid_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #2;
    check("arst_data", 32'(bus.data_rd), 32'h0);
    check("arst_valid", 32'(bus.rx_valid), 32'h0);
    check("arst_ferr", 32'(frame_err), 32'h0);
    check("arst_ovr", 32'(overrun), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    drive_bits(1'b1, 2);
    send_frame(8'h81, 1'b1); model_frame(8'h81, 1'b1, 1'b1);
    drive_bits(1'b1, 2);
    compare_q("post_rst");

    // Random frames, occasional bad stop bit, random idle gaps.
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(d, ok);
      model_frame(d, ok, 1'b1);
      drive_bits(1'b1, ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    drive_bits(1'b1, 2);
    compare_q("rand");

    check("total_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("total_ovr", 32'(ovr_cnt), 32'(exp_ovr));
    check("pulse_rules", 32'(viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
